// File: rtl/mapa_memoria.sv
// Game map memory: 4-bit cells, clear sweep, snake seed, arbitrated writes.
// Define MAPA_BORDA_EN to have the clear sweep draw an obstacle border.
module mapa_memoria #(
  parameter int MAPA_WIDTH  = 32,
  parameter int MAPA_HEIGHT = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update_renable,
  input  logic [9:0] update_rx,
  input  logic [9:0] update_ry,
  output logic [3:0] update_rdata,
  input  logic       update_wenable,
  input  logic [3:0] update_wdata,
  input  logic [9:0] update_wx,
  input  logic [9:0] update_wy,
  input  logic       fruta_wenable,
  input  logic [9:0] fruta_wx,
  input  logic [9:0] fruta_wy,
  input  logic       obstaculo_wenable,
  input  logic [9:0] obstaculo_wx,
  input  logic [9:0] obstaculo_wy,
  input  logic [9:0] vga_rx,
  input  logic [9:0] vga_ry,
  output logic [3:0] vga_rdata,
  output logic       mapa_pronto
);

  localparam int DEPTH = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [19:0] W20 = 20'(MAPA_WIDTH);
  localparam logic [19:0] H20 = 20'(MAPA_HEIGHT);
  localparam logic [19:0] D20 = 20'(DEPTH);

  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] INIT_A = AW'(3 * MAPA_WIDTH + 3);

  typedef enum logic [1:0] {
    LIMPA,
    INICIA,
    OPERA
  } estado_t;

  function automatic logic [19:0] lin(
    input logic [9:0] x,
    input logic [9:0] y
  );
    return ({10'd0, y} * W20) + {10'd0, x};
  endfunction

  function automatic logic inside_map(
    input logic [9:0]  x,
    input logic [9:0]  y,
    input logic [19:0] a
  );
    return ({10'd0, x} < W20) && ({10'd0, y} < H20) && (a < D20);
  endfunction

  logic [3:0] mem_q [DEPTH];

  estado_t       state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          fp_q, fp_d, op_q, op_d;
  logic [AW-1:0] fa_q, fa_d, oa_q, oa_d;
  logic [3:0]    upd_q, vga_q;

  logic          we;
  logic [AW-1:0] wa;
  logic [3:0]    wd;
  logic [3:0]    sweep_dat;

  logic [19:0] ur_l, vr_l, uw_l, fw_l, ow_l;
  logic        ur_ok, vr_ok, uw_ok, fw_ok, ow_ok;
  logic        opera;

  assign ur_l = lin(update_rx, update_ry);
  assign vr_l = lin(vga_rx, vga_ry);
  assign uw_l = lin(update_wx, update_wy);
  assign fw_l = lin(fruta_wx, fruta_wy);
  assign ow_l = lin(obstaculo_wx, obstaculo_wy);

  assign ur_ok = inside_map(update_rx, update_ry, ur_l);
  assign vr_ok = inside_map(vga_rx, vga_ry, vr_l);
  assign uw_ok = update_wenable &&
                 inside_map(update_wx, update_wy, uw_l);
  assign fw_ok = fruta_wenable &&
                 inside_map(fruta_wx, fruta_wy, fw_l);
  assign ow_ok = obstaculo_wenable &&
                 inside_map(obstaculo_wx, obstaculo_wy, ow_l);

  assign opera        = (state_q == OPERA);
  assign mapa_pronto  = opera;
  assign update_rdata = upd_q;
  assign vga_rdata    = vga_q;

`ifdef MAPA_BORDA_EN
  localparam logic [9:0] XL = 10'(MAPA_WIDTH - 1);
  localparam logic [9:0] YL = 10'(MAPA_HEIGHT - 1);

  logic [9:0] bx_q, bx_d, by_q, by_d;

  // x/y track the sweep address so the border needs no divider
  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    if (state_q == LIMPA) begin
      if (bx_q == XL) begin
        bx_d = '0;
        by_d = (by_q == YL) ? '0 : by_q + 10'd1;
      end else begin
        bx_d = bx_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bx_q <= '0;
      by_q <= '0;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
    end
  end

  assign sweep_dat = (bx_q == '0 || bx_q == XL ||
                      by_q == '0 || by_q == YL) ?
                     4'b0001 : 4'b0000;
`else
  assign sweep_dat = 4'b0000;
`endif

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    fp_d    = fp_q;
    fa_d    = fa_q;
    op_d    = op_q;
    oa_d    = oa_q;
    we      = 1'b0;
    wa      = '0;
    wd      = '0;
    unique case (state_q)
      LIMPA: begin
        we   = 1'b1;
        wa   = sweep_q;
        wd   = sweep_dat;
        fp_d = 1'b0;
        op_d = 1'b0;
        if (sweep_q == LAST) begin
          sweep_d = '0;
          state_d = INICIA;
        end else begin
          sweep_d = sweep_q + AW'(1);
        end
      end
      INICIA: begin
        we      = 1'b1;
        wa      = INIT_A;
        wd      = 4'b1011;
        state_d = OPERA;
      end
      OPERA: begin
        // losers of arbitration park in their source's pending slot
        if (uw_ok) begin
          we = 1'b1;
          wa = uw_l[AW-1:0];
          wd = update_wdata;
          if (fw_ok) begin
            fp_d = 1'b1;
            fa_d = fw_l[AW-1:0];
          end
          if (ow_ok) begin
            op_d = 1'b1;
            oa_d = ow_l[AW-1:0];
          end
        end else if (fw_ok || fp_q) begin
          we   = 1'b1;
          wa   = fw_ok ? fw_l[AW-1:0] : fa_q;
          wd   = 4'b0010;
          fp_d = 1'b0;
          if (ow_ok) begin
            op_d = 1'b1;
            oa_d = ow_l[AW-1:0];
          end
        end else if (ow_ok || op_q) begin
          we   = 1'b1;
          wa   = ow_ok ? ow_l[AW-1:0] : oa_q;
          wd   = 4'b0001;
          op_d = 1'b0;
        end
      end
      default: state_d = LIMPA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LIMPA;
      sweep_q <= '0;
      fp_q    <= 1'b0;
      fa_q    <= '0;
      op_q    <= 1'b0;
      oa_q    <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      fp_q    <= fp_d;
      fa_q    <= fa_d;
      op_q    <= op_d;
      oa_q    <= oa_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem_q[wa] <= wd;
    end
  end

  // reads sample the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (reset || !opera) begin
      upd_q <= 4'b0000;
      vga_q <= 4'b0000;
    end else begin
      if (update_renable) begin
        upd_q <= ur_ok ? mem_q[ur_l[AW-1:0]] : 4'b0000;
      end
      vga_q <= vr_ok ? mem_q[vr_l[AW-1:0]] : 4'b0000;
    end
  end

endmodule

// File: doc/mapa_memoria.md
MAPA_MEMORIA -- requirements
Module: mapa_memoria

Interface
REQ-001 SHALL have parameter MAPA_WIDTH, default 32, map columns (x range 0..MAPA_WIDTH-1).
REQ-002 SHALL have parameter MAPA_HEIGHT, default 24, map rows (y range 0..MAPA_HEIGHT-1).
REQ-003 SHALL have one clock and a synchronous active-high reset, with ports as follows:
- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- update_renable  input  1  update-port read request.
- update_rx, update_ry  input  10 each  update-port read coordinates.
- update_rdata  output  4  update-port read data.
- update_wenable  input  1  update-port write request.
- update_wdata  input  4  update-port write data.
- update_wx, update_wy  input  10 each  update-port write coordinates.
- fruta_wenable  input  1  fruit placement request; writes cell value 4'b0010.
- fruta_wx, fruta_wy  input  10 each  fruit coordinates.
- obstaculo_wenable  input  1  obstacle placement request; writes cell value 4'b0001.
- obstaculo_wx, obstaculo_wy  input  10 each  obstacle coordinates.
- vga_rx, vga_ry  input  10 each  render read coordinates; read every cycle.
- vga_rdata  output  4  render read data.
- mapa_pronto  output  1  high when the map is initialised and accepting requests.

Function
REQ-004 SHALL store MAPA_WIDTH*MAPA_HEIGHT 4-bit cells at address y*MAPA_WIDTH+x.
- Cell encoding: 0 empty, 1 obstacle, 2 fruit, 8+dir snake segment.
REQ-005 SHALL implement FSM states LIMPA, INICIA and OPERA; reset enters LIMPA with sweep address 0.
REQ-006 In LIMPA, SHALL write one cell per cycle in ascending address order, writing 4'b0000; after the last address it SHALL go to INICIA.
- LIMPA takes exactly MAPA_WIDTH*MAPA_HEIGHT cycles.
REQ-007 In INICIA, SHALL write 4'b1011 at (3,3) in one cycle, then go to OPERA.
REQ-008 mapa_pronto SHALL be 0 in LIMPA and INICIA, and 1 in OPERA.
REQ-009 Outside OPERA, SHALL ignore all write requests; update_rdata and vga_rdata SHALL read 0.
REQ-010 Update read: update_renable high in cycle N SHALL present the cell at cycle N+1 on update_rdata.
- update_rdata holds its last value while update_renable is low.
REQ-011 vga_rdata SHALL present the cell at (vga_rx,vga_ry) one cycle after the coordinates are sampled.
REQ-012 Read and write to the same address in the same cycle SHALL return the old data (read-first), on both read ports.
REQ-013 Write priority per cycle SHALL be update > fruta > obstaculo; only one cell is written per cycle.
REQ-014 A fruta or obstaculo request that loses arbitration SHALL be latched in a one-entry pending slot for that source.
- The pending write is committed in the first cycle with no higher-priority write.
- A new request from the same source overwrites its pending slot.
- A direct request in a free cycle commits immediately and clears that source's pending slot.
REQ-015 Any request with x>=MAPA_WIDTH or y>=MAPA_HEIGHT SHALL perform no write; a read with such coordinates SHALL return 4'b0000.
REQ-016 Coordinate arithmetic SHALL be at least 20 bits wide so the address computation cannot overflow.

Reset
REQ-017 Reset SHALL set: update_rdata=0, vga_rdata=0, mapa_pronto=0, both pending slots empty, FSM=LIMPA, sweep address=0.
REQ-018 Reset asserted in any state, including mid-LIMPA, SHALL restart the full sweep from address 0 on the cycle after reset deasserts.
- Cell contents are not guaranteed until LIMPA completes.

Configuration
REQ-019 With macro MAPA_BORDA_EN defined, LIMPA SHALL write 4'b0001 to every cell with x=0, x=MAPA_WIDTH-1, y=0 or y=MAPA_HEIGHT-1, and 0 elsewhere.
- Without MAPA_BORDA_EN, all cells are cleared to 0.
- LIMPA duration is identical in both builds.

Verification
REQ-020 Use MAPA_WIDTH=8, MAPA_HEIGHT=6. Pulse reset, then poll mapa_pronto.
- Required: mapa_pronto rises exactly 49 cycles after reset deasserts (48 LIMPA cycles + 1 INICIA cycle).
- Required: update read of (3,3) returns 4'b1011; read of (0,0) returns 0, or 1 with MAPA_BORDA_EN.
REQ-021 In OPERA, issue update write 4'b1010 to (5,2) and update read of (5,2) in the same cycle.
- Required: the read returns 0 (old data); a read of (5,2) on the next cycle returns 4'b1010.
REQ-022 In one cycle, issue update write to (1,1), fruta to (2,2) and obstaculo to (4,4).
- Required: (1,1) is written in cycle N, (2,2)=2 in N+1 and (4,4)=1 in N+2.
REQ-023 Issue update write to (9,1) and fruta write to (1,7).
- Required: no cell changes; update read of (9,1) returns 0.
REQ-024 Assert reset for 1 cycle midway through LIMPA after a prior run wrote (5,2)=4'b1010.
- Required: mapa_pronto stays 0 for 49 cycles after reset deasserts, then (5,2) reads 0.
